// File: rtl/lsu.sv
// RV32I load/store unit: req/gnt/rvalid handshake to data memory, store lane
// alignment, load extraction with sign/zero extension, timeout abort.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_func3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_addr_i,
    output logic        hold_flag_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic               we_q;
    logic [2:0]         func3_q;
    logic [1:0]         addr_lo_q;
    logic [4:0]         rd_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               bad_c;
    logic               timeout_c;
    logic               done_ok_c;
    logic               done_err_c;
    logic [31:0]        lane_wdata_c;
    logic [3:0]         lane_wmask_c;
    logic [31:0]        load_c;
    logic [31:0]        byte_sh_c;
    logic [31:0]        half_sh_c;

    // Illegal func3 or misaligned address for the requested access size
    always_comb begin
        bad_c = (req_func3_i == 3'b011) || (req_func3_i[2:1] == 2'b11)
             || (req_we_i && req_func3_i[2])
             || ((req_func3_i[1:0] == 2'b01) && req_addr_i[0])
             || ((req_func3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    end

    assign timeout_c = (TIMEOUT_CYCLES != 0)
                    && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

    assign hold_flag_o = ((state_q == IDLE) && req_valid_i)
                      || (state_q == REQ) || (state_q == WAIT);

    // Next-state logic; response or grant wins over a coincident timeout
    always_comb begin
        state_d    = state_q;
        done_ok_c  = 1'b0;
        done_err_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (bad_c) begin
                        state_d    = DONE;
                        done_err_c = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end else if (timeout_c) begin
                    state_d    = DONE;
                    done_err_c = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d   = DONE;
                    done_ok_c = 1'b1;
                end else if (timeout_c) begin
                    state_d    = DONE;
                    done_err_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Store byte-lane replication and write mask
    always_comb begin
        case (req_func3_i[1:0])
            2'b00: begin
                lane_wdata_c = {4{req_wdata_i[7:0]}};
                lane_wmask_c = 4'b0001 << req_addr_i[1:0];
            end
            2'b01: begin
                lane_wdata_c = {2{req_wdata_i[15:0]}};
                lane_wmask_c = 4'b0011 << {req_addr_i[1], 1'b0};
            end
            default: begin
                lane_wdata_c = req_wdata_i;
                lane_wmask_c = 4'b1111;
            end
        endcase
    end

    // Load extraction and extension
    always_comb begin
        byte_sh_c = mem_rdata_i >> {addr_lo_q, 3'b000};
        half_sh_c = mem_rdata_i >> {addr_lo_q[1], 4'b0000};
        case (func3_q)
            3'b000:  load_c = {{24{byte_sh_c[7]}}, byte_sh_c[7:0]};
            3'b001:  load_c = {{16{half_sh_c[15]}}, half_sh_c[15:0]};
            3'b100:  load_c = {24'h0, byte_sh_c[7:0]};
            3'b101:  load_c = {16'h0, half_sh_c[15:0]};
            default: load_c = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            func3_q     <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= 5'd0;
            cnt_q       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wmask_o <= 4'h0;
            mem_wdata_o <= 32'h0;
            rd_wen_o    <= 1'b0;
            rd_addr_o   <= 5'd0;
            rd_data_o   <= 32'h0;
            err_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= ((state_q == REQ) || (state_q == WAIT)) ? cnt_q + CNT_W'(1) : '0;
            if ((state_q == IDLE) && req_valid_i) begin
                we_q      <= req_we_i;
                func3_q   <= req_func3_i;
                addr_lo_q <= req_addr_i[1:0];
                rd_q      <= req_rd_addr_i;
                if (!bad_c) begin
                    mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                    mem_wdata_o <= lane_wdata_c;
                    mem_wmask_o <= req_we_i ? lane_wmask_c : 4'h0;
                end
            end
            mem_req_o <= (state_d == REQ);
            mem_we_o  <= (state_d == REQ) && ((state_q == IDLE) ? req_we_i : we_q);
            err_o     <= done_err_c;
            rd_wen_o  <= done_ok_c && !we_q && (rd_q != 5'd0);
            if (done_ok_c && !we_q) begin
                rd_addr_o <= rd_q;
                rd_data_o <= load_c;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; a second instance with a short
// timeout covers the abort path.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        m_hold, m_rd_wen, m_err, m_mem_req, m_mem_we;
    logic [4:0]  m_rd_addr;
    logic [31:0] m_rd_data, m_mem_addr, m_mem_wdata;
    logic [3:0]  m_mem_wmask;
    logic        t_hold, t_rd_wen, t_err, t_mem_req, t_mem_we;
    logic [4:0]  t_rd_addr;
    logic [31:0] t_rd_data, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_wmask;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_func3_i(req_func3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_addr_i(req_rd),
        .hold_flag_o(m_hold), .rd_addr_o(m_rd_addr), .rd_data_o(m_rd_data),
        .rd_wen_o(m_rd_wen), .err_o(m_err),
        .mem_req_o(m_mem_req), .mem_we_o(m_mem_we), .mem_addr_o(m_mem_addr),
        .mem_wmask_o(m_mem_wmask), .mem_wdata_o(m_mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_func3_i(req_func3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_addr_i(req_rd),
        .hold_flag_o(t_hold), .rd_addr_o(t_rd_addr), .rd_data_o(t_rd_data),
        .rd_wen_o(t_rd_wen), .err_o(t_err),
        .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr),
        .mem_wmask_o(t_mem_wmask), .mem_wdata_o(t_mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    // Minimum-latency load; returns what the selected instance shows in DONE
    task automatic run_load(input logic sel, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [4:0] rd,
                            output logic wen, output logic [31:0] data,
                            output logic [4:0] raddr, output logic err,
                            output logic hold_ok, output logic mreq);
        logic h_acc, h_req, h_wait;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = f3; req_addr = addr; req_rd = rd;
        @(negedge clk); h_acc = sel ? t_hold : m_hold;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mreq = sel ? t_mem_req : m_mem_req; h_req = sel ? t_hold : m_hold;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk); h_wait = sel ? t_hold : m_hold;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        wen   = sel ? t_rd_wen : m_rd_wen;
        data  = sel ? t_rd_data : m_rd_data;
        raddr = sel ? t_rd_addr : m_rd_addr;
        err   = sel ? t_err : m_err;
        hold_ok = h_acc && h_req && h_wait && !(sel ? t_hold : m_hold);
    endtask

    function automatic logic [82:0] m_outs();
        return {m_hold, m_rd_wen, m_err, m_mem_req, m_mem_we, m_rd_addr, m_rd_data,
                m_mem_addr[7:0], m_mem_wmask, m_mem_wdata[15:0], m_rd_addr, m_mem_addr[31:8]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_outs(), m_mem_wdata} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {m_outs(), m_mem_wdata});
        end
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic wen, err, hok, mreq;
        logic [31:0] data;
        logic [4:0] ra;
        logic [2:0] f3 [5] = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] ad [5] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rdv [5] = '{32'hDEADBEEF, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000};
        logic [31:0] exp [5] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF};
        for (int i = 0; i < 5; i++) begin
            run_load(1'b0, f3[i], ad[i], rdv[i], 5'(5 + i), wen, data, ra, err, hok, mreq);
            total++;
            if ({wen, err, ra, data} !== {1'b1, 1'b0, 5'(5 + i), exp[i]}) begin
                bad++;
                $display("FAIL load_%0d: wen=%b err=%b rd=%0d data=%h want wen=1 err=0 rd=%0d data=%h",
                         i, wen, err, ra, data, 5 + i, exp[i]);
            end
            total++;
            if ({hok, mreq} !== 2'b11) begin
                bad++; $display("FAIL load_hold_%0d: hold_ok=%b mem_req=%b want 1 1", i, hok, mreq);
            end
        end
        total++;
        if (m_mem_addr !== 32'h100) begin
            bad++; $display("FAIL load_addr: got %h want 00000100", m_mem_addr);
        end
        @(negedge clk);
        total++;
        if (m_rd_wen !== 1'b0) begin
            bad++; $display("FAIL load_wen_pulse: got %b want 0", m_rd_wen);
        end
    endtask

    task automatic test_store();
        int reqs = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b001; req_addr = 32'h202;
        req_wdata = 32'h1234ABCD; req_rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); reqs += int'(m_mem_req);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        reqs += int'(m_mem_req);
        total++;
        if ({m_mem_we, m_mem_addr, m_mem_wmask, m_mem_wdata} !== {1'b1, 32'h200, 4'b1100, 32'hABCDABCD}) begin
            bad++;
            $display("FAIL sh_bus: we=%b addr=%h mask=%b wdata=%h want 1 00000200 1100 abcdabcd",
                     m_mem_we, m_mem_addr, m_mem_wmask, m_mem_wdata);
        end
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        total++;
        if ({reqs, m_mem_req, m_hold} !== {32'd4, 1'b0, 1'b1}) begin
            bad++; $display("FAIL sh_req: cycles=%0d req=%b hold=%b want 4 0 1", reqs, m_mem_req, m_hold);
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({m_rd_wen, m_err, m_hold} !== 3'b000) begin
            bad++; $display("FAIL sh_done: wen=%b err=%b hold=%b want 0 0 0", m_rd_wen, m_err, m_hold);
        end
        // SB lane placement, observed in REQ
        @(posedge clk); #1;
        req_valid = 1'b1; req_func3 = 3'b000; req_addr = 32'h301; req_wdata = 32'h000000A5;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        total++;
        if ({m_mem_addr, m_mem_wmask, m_mem_wdata} !== {32'h300, 4'b0010, 32'hA5A5A5A5}) begin
            bad++;
            $display("FAIL sb_bus: addr=%h mask=%b wdata=%h want 00000300 0010 a5a5a5a5",
                     m_mem_addr, m_mem_wmask, m_mem_wdata);
        end
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; req_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [3:0] cases_we [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0] cases_f3 [3] = '{3'b010, 3'b011, 3'b100};
        logic [31:0] cases_ad [3] = '{32'h101, 32'h100, 32'h100};
        for (int i = 0; i < 3; i++) begin
            int reqs = 0;
            logic h_acc;
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = cases_we[i][0]; req_func3 = cases_f3[i];
            req_addr = cases_ad[i]; req_rd = 5'd9;
            @(negedge clk); h_acc = m_hold; reqs += int'(m_mem_req);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            reqs += int'(m_mem_req);
            total++;
            if ({m_err, m_rd_wen, m_hold, h_acc} !== 4'b1001) begin
                bad++;
                $display("FAIL err_%0d: err=%b wen=%b hold=%b hold_acc=%b want 1 0 0 1",
                         i, m_err, m_rd_wen, m_hold, h_acc);
            end
            @(negedge clk);
            reqs += int'(m_mem_req);
            total++;
            if ({reqs, m_err} !== {32'd0, 1'b0}) begin
                bad++; $display("FAIL err_after_%0d: req_cycles=%0d err=%b want 0 0", i, reqs, m_err);
            end
        end
        req_we = 1'b0;
    endtask

    task automatic test_timeout();
        logic wen, err, hok, mreq;
        logic [31:0] data;
        logic [4:0] ra;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h100; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({t_mem_req, t_mem_we, t_mem_wmask, t_err} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
            bad++; $display("FAIL to_req: req=%b we=%b mask=%b err=%b want 1 0 0000 0",
                            t_mem_req, t_mem_we, t_mem_wmask, t_err);
        end
        @(negedge clk);
        total++;
        if ({t_err, t_mem_req, t_hold, t_rd_wen} !== 4'b1000) begin
            bad++; $display("FAIL to_abort: err=%b req=%b hold=%b wen=%b want 1 0 0 0",
                            t_err, t_mem_req, t_hold, t_rd_wen);
        end
        @(negedge clk);
        total++;
        if ({t_err, t_hold} !== 2'b00) begin
            bad++; $display("FAIL to_idle: err=%b hold=%b want 0 0", t_err, t_hold);
        end
        run_load(1'b1, 3'b010, 32'h104, 32'h0BADF00D, 5'd12, wen, data, ra, err, hok, mreq);
        total++;
        if ({wen, err, ra, data, hok, t_mem_wdata[0] === 1'bx} !== {1'b1, 1'b0, 5'd12, 32'h0BADF00D, 1'b1, 1'b0}) begin
            bad++; $display("FAIL to_recover: wen=%b err=%b rd=%0d data=%h hold_ok=%b want 1 0 12 0badf00d 1",
                            wen, err, ra, data, hok);
        end
    endtask

    task automatic test_reset_in_flight();
        logic wen, err, hok, mreq;
        logic [31:0] data;
        logic [4:0] ra;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h100; req_rd = 5'd6;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({m_outs(), m_mem_wdata} !== '0) begin
            bad++; $display("FAIL rst_wait_outputs: got %h want 0", {m_outs(), m_mem_wdata});
        end
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({m_rd_wen, m_err, m_mem_req, m_hold} !== 4'b0000) begin
            bad++; $display("FAIL stale_rvalid: wen=%b err=%b req=%b hold=%b want 0 0 0 0",
                            m_rd_wen, m_err, m_mem_req, m_hold);
        end
        run_load(1'b0, 3'b010, 32'h108, 32'h12345678, 5'd0, wen, data, ra, err, hok, mreq);
        total++;
        if ({wen, err, hok} !== 3'b001) begin
            bad++; $display("FAIL rd0_load: wen=%b err=%b hold_ok=%b want 0 0 1", wen, err, hok);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store();
        test_errors();
        test_timeout();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit completing the RV32I memory instructions (LB/LH/LW/LBU/LHU/SB/SH/SW) for the core. It accepts one decoded memory request per operation from the execute stage and raises `hold_flag_o` toward ctrl while busy. It runs a request/grant/response handshake to the data memory bus, aligns store data into byte lanes and extracts and sign/zero-extends load data. Load results go to the register file write port.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles in REQ+WAIT before abort; 0 disables timeout (16-bit counter).
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid_i` in 1: memory request from ex.
- `req_we_i` in 1: 1 store, 0 load.
- `req_func3_i` in 3: RV32I func3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr_i` in 32: byte address (rs1+imm, computed in ex).
- `req_wdata_i` in 32: store data (rs2).
- `req_rd_addr_i` in 5: load destination.
- `hold_flag_o` out 1: stall request to ctrl.
- `rd_addr_o` out 5: writeback address.
- `rd_data_o` out 32: writeback data.
- `rd_wen_o` out 1: writeback enable, one-cycle pulse.
- `err_o` out 1: one-cycle pulse on misaligned, illegal func3 or timeout.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write.
- `mem_addr_o` out 32: word-aligned address {addr[31:2],2'b00}.
- `mem_wmask_o` out 4: byte write mask (0 for loads).
- `mem_wdata_o` out 32: lane-replicated store data.
- `mem_gnt_i` in 1: bus accepted request.
- `mem_rvalid_i` in 1: response valid (loads and stores).
- `mem_rdata_i` in 32: read data.

## Operation
- FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
- IDLE: on `req_valid_i`, register we/func3/addr/wdata/rd; legality check on inputs. Legal → REQ; misaligned (H/HU/SH addr[0]=1, W/SW addr[1:0]≠0) or illegal func3 (011,110,111; store func3 > 010) → DONE with error, no bus access.
- REQ: `mem_req_o`=1, bus outputs stable from registered fields. `mem_gnt_i` → WAIT. `mem_rvalid_i` ignored in REQ.
- WAIT: `mem_req_o`=0; `mem_rvalid_i` → DONE, capture processed load data.
- DONE (exactly one cycle): load OK → `rd_wen_o`=1 unless rd=0; store → `rd_wen_o`=0; error → `err_o`=1, `rd_wen_o`=0. `req_valid_i` ignored (pipeline advances at end of this cycle). Next → IDLE.
- Timeout: counter cleared on IDLE→REQ, increments each REQ/WAIT cycle; on reaching TIMEOUT_CYCLES (≠0) → DONE with error, `mem_req_o` drops.
- `hold_flag_o` = (IDLE & req_valid_i) | REQ | WAIT; combinational; low in DONE.
- Store lanes: SB wdata={4{b[7:0]}}, mask=4'b0001<<addr[1:0]; SH wdata={2{h[15:0]}}, mask=4'b0011<<{addr[1],1'b0}; SW mask 4'b1111.
- Load extract: LB/LBU byte rdata[8*addr[1:0]+:8]; LH/LHU half rdata[16*addr[1]+:16]; LB/LH sign-extend, BU/HU zero-extend, LW full word.
- `mem_rvalid_i` in IDLE/DONE ignored (stale responses after reset/abort).

## Timing
- Reset values: all outputs 0; `mem_addr_o`, `mem_wdata_o`, `mem_wmask_o` 0; state IDLE; counter 0.
- `rst` high at any edge returns to IDLE immediately; in-flight access abandoned, no writeback, no `err_o`.
- Minimum latency: accept cycle T, REQ at T+1 (gnt same cycle), WAIT T+2 (rvalid same cycle), DONE T+3 with `rd_wen_o`. `hold_flag_o` high T..T+2.
- Error path: accept T, DONE T+1 with `err_o`; `hold_flag_o` high only at T.
- All DONE outputs registered; bus outputs registered.

## Test plan
- LW addr 0x100, gnt 1st REQ cycle, rvalid next, rdata 0xDEADBEEF, rd=5 → `rd_wen_o` pulse at T+3, rd_addr 5, rd_data 0xDEADBEEF; `hold_flag_o` high T..T+2.
- LB addr 0x103 rdata 0x80FF_0000 → rd_data 0xFFFF_FF80; LBU same → 0x0000_0080; LHU addr 0x102 → 0x0000_80FF.
- SH addr 0x202 wdata 0x1234_ABCD → mem_addr 0x200, wmask 4'b1100, wdata 0xABCD_ABCD; gnt delayed 3 cycles → no `rd_wen_o`, DONE after rvalid.
- LW addr 0x101 → `err_o` at T+1, `mem_req_o` never asserted, no writeback.
- TIMEOUT_CYCLES=4, gnt never asserted → `err_o` pulse, `mem_req_o` drops, FSM back to IDLE; subsequent LW completes normally.
- `rst` asserted in WAIT, then rvalid arrives → all outputs 0, rvalid ignored, no `rd_wen_o`; load with rd=0 completes without `rd_wen_o`.
